pw_cache: RTL and testbench

- Page-walk cache: the responder that sits on the far end of the PWU's pw_c request/response interface.
- Accepts a virtual-address lookup each cycle. Returns the cached 16-bit physical frame one cycle later, or zero on a miss.
- A fill port writes completed walk results back in. A flush input invalidates all entries.
- Small fully-associative array with round-robin replacement, plus saturating hit/miss counters for performance debug.

---
 rtl/pw_cache.sv | 130 +++++++++++++
 tb/tb_pw_cache.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/pw_cache.sv
// Page-walk cache: fully-associative VA-tag -> frame store answering the PWU's pw_c lookups
// with one cycle of latency, plus a fill port, a flush input and saturating hit/miss counters.
module pw_cache #(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned VA_W    = 32,
   parameter int unsigned PA_W    = 16,
   parameter int unsigned PAGE_SH = 12,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [VA_W-1:0]  pw_c_va_i,
   input  logic             pw_c_vld_i,
   output logic [PA_W-1:0]  pw_c_pa_o,
   output logic             pw_c_hit_o,
   output logic             pw_c_rsp_vld_o,
   input  logic             fill_vld_i,
   input  logic [VA_W-1:0]  fill_va_i,
   input  logic [PA_W-1:0]  fill_pa_i,
   input  logic             flush_i,
   output logic [CNT_W-1:0] hit_cnt_o,
   output logic [CNT_W-1:0] miss_cnt_o
);

   localparam int unsigned TAG_W = VA_W - PAGE_SH;
   localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q   [ENTRIES];
   logic [PA_W-1:0]    frame_q [ENTRIES];
   logic [IDX_W-1:0]   ptr_q;

   logic [TAG_W-1:0]   lk_tag;
   logic [TAG_W-1:0]   fill_tag;
   logic               lk_hit_c;
   logic [PA_W-1:0]    lk_pa_c;
   logic               fill_hit_c;
   logic [IDX_W-1:0]   fill_hit_idx_c;
   logic               inv_found_c;
   logic [IDX_W-1:0]   inv_idx_c;
   logic [IDX_W-1:0]   wr_idx_c;
   logic               ptr_bump_c;

   assign lk_tag   = pw_c_va_i[VA_W-1:PAGE_SH];
   assign fill_tag = fill_va_i[VA_W-1:PAGE_SH];

   // Page-offset bits play no part in tag matching.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{pw_c_va_i[PAGE_SH-1:0], fill_va_i[PAGE_SH-1:0]};

   // Lookup match against the registered (pre-fill, pre-flush) array.
   always_comb begin
      lk_hit_c = 1'b0;
      lk_pa_c  = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && (tag_q[i] == lk_tag)) begin
            lk_hit_c = 1'b1;
            lk_pa_c  = frame_q[i];
         end
      end
   end

   // Fill victim: existing tag first, then lowest invalid slot, then round-robin pointer.
   always_comb begin
      fill_hit_c     = 1'b0;
      fill_hit_idx_c = '0;
      inv_found_c    = 1'b0;
      inv_idx_c      = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
         if (valid_q[i] && (tag_q[i] == fill_tag)) begin
            fill_hit_c     = 1'b1;
            fill_hit_idx_c = IDX_W'(i);
         end
         if (!inv_found_c && !valid_q[i]) begin
            inv_found_c = 1'b1;
            inv_idx_c   = IDX_W'(i);
         end
      end
      ptr_bump_c = 1'b0;
      if (fill_hit_c) begin
         wr_idx_c = fill_hit_idx_c;
      end else if (inv_found_c) begin
         wr_idx_c = inv_idx_c;
      end else begin
         wr_idx_c   = ptr_q;
         ptr_bump_c = 1'b1;
      end
   end

   // Control state, response and counters.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q        <= '0;
         ptr_q          <= '0;
         pw_c_rsp_vld_o <= 1'b0;
         pw_c_hit_o     <= 1'b0;
         pw_c_pa_o      <= '0;
         hit_cnt_o      <= '0;
         miss_cnt_o     <= '0;
      end else begin
         pw_c_rsp_vld_o <= pw_c_vld_i;
         pw_c_hit_o     <= pw_c_vld_i && lk_hit_c;
         pw_c_pa_o      <= (pw_c_vld_i && lk_hit_c) ? lk_pa_c : '0;
         if (pw_c_vld_i && lk_hit_c && (hit_cnt_o != '1)) begin
            hit_cnt_o <= hit_cnt_o + CNT_W'(1);
         end
         if (pw_c_vld_i && !lk_hit_c && (miss_cnt_o != '1)) begin
            miss_cnt_o <= miss_cnt_o + CNT_W'(1);
         end
         if (flush_i) begin
            valid_q <= '0;
            ptr_q   <= '0;
         end else if (fill_vld_i) begin
            valid_q[wr_idx_c] <= 1'b1;
            if (ptr_bump_c) begin
               ptr_q <= ptr_q + IDX_W'(1);
            end
         end
      end
   end

   // Tag/frame storage carries no reset; valid bits qualify it.
   always_ff @(posedge clk_i) begin
      if (!reset_i && !flush_i && fill_vld_i) begin
         tag_q[wr_idx_c]   <= fill_tag;
         frame_q[wr_idx_c] <= fill_pa_i;
      end
   end

endmodule

// File: tb/tb_pw_cache.sv
// Directed bench for pw_cache: table of per-cycle vectors with expected responses,
// plus hand-written saturation and reset-during-response sequences.
module tb_pw_cache;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic [31:0] pw_c_va_i;
   logic        pw_c_vld_i;
   logic [15:0] pw_c_pa_o;
   logic        pw_c_hit_o;
   logic        pw_c_rsp_vld_o;
   logic        fill_vld_i;
   logic [31:0] fill_va_i;
   logic [15:0] fill_pa_i;
   logic        flush_i;
   logic [15:0] hit_cnt_o;
   logic [15:0] miss_cnt_o;

   int tests  = 0;
   int errors = 0;
   int exp_hits  = 0;
   int exp_miss  = 0;

   pw_cache dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .pw_c_va_i      (pw_c_va_i),
      .pw_c_vld_i     (pw_c_vld_i),
      .pw_c_pa_o      (pw_c_pa_o),
      .pw_c_hit_o     (pw_c_hit_o),
      .pw_c_rsp_vld_o (pw_c_rsp_vld_o),
      .fill_vld_i     (fill_vld_i),
      .fill_va_i      (fill_va_i),
      .fill_pa_i      (fill_pa_i),
      .flush_i        (flush_i),
      .hit_cnt_o      (hit_cnt_o),
      .miss_cnt_o     (miss_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        lk;
      logic [31:0] lk_va;
      logic        fl;
      logic [31:0] fl_va;
      logic [15:0] fl_pa;
      logic        flush;
      logic        e_vld;
      logic        e_hit;
      logic [15:0] e_pa;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] tv(input int t);
      return 32'(t) << 12;
   endfunction

   function automatic vec_t mk(input logic lk, input logic [31:0] lk_va,
                               input logic fl, input logic [31:0] fl_va, input logic [15:0] fl_pa,
                               input logic flush, input logic e_hit, input logic [15:0] e_pa);
      vec_t v;
      v.lk = lk; v.lk_va = lk_va; v.fl = fl; v.fl_va = fl_va; v.fl_pa = fl_pa;
      v.flush = flush; v.e_vld = lk; v.e_hit = e_hit; v.e_pa = e_pa;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      pw_c_vld_i = 1'b0; pw_c_va_i = '0;
      fill_vld_i = 1'b0; fill_va_i = '0; fill_pa_i = '0;
      flush_i    = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] va);
      idle_inputs();
      pw_c_vld_i = 1'b1;
      pw_c_va_i  = va;
      step();
   endtask

   initial begin
      reset_i = 1'b1;
      idle_inputs();
      step();
      step();
      chk("reset_rsp_vld", 32'(pw_c_rsp_vld_o), 32'd0);
      chk("reset_hit",     32'(pw_c_hit_o),     32'd0);
      chk("reset_pa",      32'(pw_c_pa_o),      32'd0);
      chk("reset_hit_cnt", 32'(hit_cnt_o),      32'd0);
      chk("reset_miss_cnt",32'(miss_cnt_o),     32'd0);
      reset_i = 1'b0;

      // lk, lk_va, fl, fl_va, fl_pa, flush, exp_hit, exp_pa
      vecs.push_back(mk(1, 32'h0000_1000, 0, 0, 0, 0, 0, 16'h0000));
      vecs.push_back(mk(0, 0, 1, 32'h0000_5123, 16'h00A7, 0, 0, 0));
      vecs.push_back(mk(1, 32'h0000_5FFF, 0, 0, 0, 0, 1, 16'h00A7));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
      for (int t = 1; t <= 9; t++) vecs.push_back(mk(0, 0, 1, tv(t), 16'(16'h0100 + t), 0, 0, 0));
      vecs.push_back(mk(1, tv(1), 0, 0, 0, 0, 0, 16'h0000));
      vecs.push_back(mk(1, tv(2), 0, 0, 0, 0, 1, 16'h0102));
      vecs.push_back(mk(1, tv(9), 0, 0, 0, 0, 1, 16'h0109));
      vecs.push_back(mk(0, 0, 1, tv(3), 16'h0055, 0, 0, 0));
      vecs.push_back(mk(1, tv(3), 0, 0, 0, 0, 1, 16'h0055));
      // Pointer must still be 1: tag 0xA replaces tag 2, not tag 3.
      vecs.push_back(mk(0, 0, 1, tv(10), 16'h010A, 0, 0, 0));
      vecs.push_back(mk(1, tv(2), 0, 0, 0, 0, 0, 16'h0000));
      vecs.push_back(mk(1, tv(3), 0, 0, 0, 0, 1, 16'h0055));
      vecs.push_back(mk(1, tv(4), 0, 0, 0, 0, 1, 16'h0104));
      vecs.push_back(mk(1, tv(8), 0, 0, 0, 0, 1, 16'h0108));
      vecs.push_back(mk(1, tv(10), 0, 0, 0, 0, 1, 16'h010A));
      vecs.push_back(mk(1, tv(32), 1, tv(32), 16'h0200, 0, 0, 16'h0000));
      vecs.push_back(mk(1, tv(32), 0, 0, 0, 0, 1, 16'h0200));
      vecs.push_back(mk(1, tv(32), 1, tv(33), 16'h0210, 1, 1, 16'h0200));
      vecs.push_back(mk(1, tv(33), 0, 0, 0, 0, 0, 16'h0000));
      vecs.push_back(mk(1, tv(32), 0, 0, 0, 0, 0, 16'h0000));
      vecs.push_back(mk(1, tv(4), 0, 0, 0, 0, 0, 16'h0000));
      vecs.push_back(mk(1, tv(9), 0, 0, 0, 0, 0, 16'h0000));
      vecs.push_back(mk(1, tv(10), 0, 0, 0, 0, 0, 16'h0000));

      foreach (vecs[k]) begin
         pw_c_vld_i = vecs[k].lk;
         pw_c_va_i  = vecs[k].lk_va;
         fill_vld_i = vecs[k].fl;
         fill_va_i  = vecs[k].fl_va;
         fill_pa_i  = vecs[k].fl_pa;
         flush_i    = vecs[k].flush;
         step();
         if (vecs[k].e_vld) begin
            if (vecs[k].e_hit) exp_hits++;
            else               exp_miss++;
         end
         chk($sformatf("v%0d_rsp_vld", k), 32'(pw_c_rsp_vld_o), 32'(vecs[k].e_vld));
         chk($sformatf("v%0d_hit", k),     32'(pw_c_hit_o),     32'(vecs[k].e_hit));
         chk($sformatf("v%0d_pa", k),      32'(pw_c_pa_o),      32'(vecs[k].e_pa));
         chk($sformatf("v%0d_hit_cnt", k), 32'(hit_cnt_o),      32'(exp_hits));
         chk($sformatf("v%0d_miss_cnt", k),32'(miss_cnt_o),     32'(exp_miss));
      end

      // Drive the miss counter up to saturation with back-to-back misses.
      idle_inputs();
      pw_c_vld_i = 1'b1;
      pw_c_va_i  = tv(16'h7777);
      while (exp_miss < 65535) begin
         step();
         exp_miss++;
      end
      chk("sat_reach", 32'(miss_cnt_o), 32'h0000_FFFF);
      step();
      chk("sat_hold",  32'(miss_cnt_o), 32'h0000_FFFF);
      chk("sat_hit_cnt", 32'(hit_cnt_o), 32'(exp_hits));
      chk("sat_rsp_vld", 32'(pw_c_rsp_vld_o), 32'd1);

      // Reset with a lookup outstanding kills the response and clears counters.
      lookup(tv(5));
      chk("pre_reset_rsp_vld", 32'(pw_c_rsp_vld_o), 32'd1);
      reset_i = 1'b1;
      step();
      chk("rst_mid_rsp_vld",  32'(pw_c_rsp_vld_o), 32'd0);
      chk("rst_mid_hit_cnt",  32'(hit_cnt_o),      32'd0);
      chk("rst_mid_miss_cnt", 32'(miss_cnt_o),     32'd0);
      reset_i = 1'b0;
      lookup(tv(1));
      chk("post_reset_rsp_vld", 32'(pw_c_rsp_vld_o), 32'd1);
      chk("post_reset_hit",     32'(pw_c_hit_o),     32'd0);
      chk("post_reset_miss",    32'(miss_cnt_o),     32'd1);
      idle_inputs();
      step();
      chk("idle_rsp_vld", 32'(pw_c_rsp_vld_o), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
